// File: rtl/xlib_avalon_bus_w.sv
// NR-port to single-master Avalon burst-write arbiter.
// Fixed priority (highest index wins), grant locked until the last beat of a burst is accepted.
module xlib_avalon_bus_w #(
    parameter int unsigned NR = 4,
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 32,
    parameter int unsigned BL = 4,
    parameter int unsigned BI = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic [NR-1:0]        s_wrdy_o,
    input  logic [NR-1:0]        s_wval_i,
    input  logic [NR*BL-1:0]     s_wlen_i,
    input  logic [NR*AW-1:0]     s_waddr_i,
    input  logic [NR*DW-1:0]     s_wdata_i,
    input  logic [NR*DW/8-1:0]   s_wbe_i,
    output logic [NR-1:0]        s_wdone_o,
    input  logic                 m_wrdy_i,
    output logic                 m_wval_o,
    output logic [BL-1:0]        m_wlen_o,
    output logic [AW-1:0]        m_waddr_o,
    output logic [DW-1:0]        m_wdata_o,
    output logic [DW/8-1:0]      m_wbe_o
);

    localparam int unsigned IW = $clog2(NR);
    localparam int unsigned BW = DW / 8;
    localparam logic [BL-1:0] BiV = BL'(BI);

    typedef enum logic {StIdle, StBusy} state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   rid_q, rid_d;
    logic [BL-1:0]   wcnt_q, wcnt_d;
    logic [BL-1:0]   lenq_q, lenq_d;
    logic            first_q, first_d;
    logic [NR-1:0]   wdone_q, wdone_d;

    logic [BL-1:0]   len_a  [NR];
    logic [AW-1:0]   addr_a [NR];
    logic [DW-1:0]   data_a [NR];
    logic [BW-1:0]   be_a   [NR];

    logic [IW-1:0]   pick;
    logic [BL-1:0]   elen;
    logic            acc;
    logic            last;

    always_comb begin
        for (int i = 0; i < NR; i++) begin
            len_a[i]  = s_wlen_i[i*BL +: BL];
            addr_a[i] = s_waddr_i[i*AW +: AW];
            data_a[i] = s_wdata_i[i*DW +: DW];
            be_a[i]   = s_wbe_i[i*BW +: BW];
        end
    end

    // Ascending scan so the highest requesting index is the one left standing.
    always_comb begin
        pick = '0;
        for (int i = 0; i < NR; i++) begin
            if (s_wval_i[i]) begin
                pick = IW'(i);
            end
        end
    end

    // Data-path mux follows rid_q even when idle; rid_q resets to 0 so port 0 shows in reset.
    assign m_wlen_o  = len_a[rid_q];
    assign m_waddr_o = addr_a[rid_q];
    assign m_wdata_o = data_a[rid_q];
    assign m_wbe_o   = be_a[rid_q];
    assign m_wval_o  = (state_q == StBusy) && s_wval_i[rid_q];

    always_comb begin
        s_wrdy_o = '0;
        for (int i = 0; i < NR; i++) begin
            s_wrdy_o[i] = (state_q == StBusy) && m_wrdy_i && (rid_q == IW'(i));
        end
    end

    assign acc       = m_wval_o && m_wrdy_i;
    assign elen      = first_q ? len_a[rid_q] : lenq_q;
    assign last      = acc && (wcnt_q == elen);
    assign s_wdone_o = wdone_q;

    always_comb begin
        state_d = state_q;
        rid_d   = rid_q;
        wcnt_d  = wcnt_q;
        lenq_d  = lenq_q;
        first_d = first_q;
        wdone_d = '0;
        unique case (state_q)
            StIdle: begin
                if (|s_wval_i) begin
                    rid_d   = pick;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (acc) begin
                    if (first_q) begin
                        lenq_d  = len_a[rid_q];
                        first_d = 1'b0;
                    end
                    if (last) begin
                        wcnt_d         = BiV;
                        state_d        = StIdle;
                        first_d        = 1'b1;
                        wdone_d[rid_q] = 1'b1;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            rid_q   <= '0;
            wcnt_q  <= BiV;
            lenq_q  <= '0;
            first_q <= 1'b1;
            wdone_q <= '0;
        end else begin
            state_q <= state_d;
            rid_q   <= rid_d;
            wcnt_q  <= wcnt_d;
            lenq_q  <= lenq_d;
            first_q <= first_d;
            wdone_q <= wdone_d;
        end
    end

endmodule

// File: doc/xlib_avalon_bus_w.md
Name: xlib_avalon_bus_w

Overview:
- NR-port to single-master Avalon burst-write arbiter; write-side counterpart of the burst-read bus arbiter used by the DMA engines.
- Each requester presents a complete burst: address and length held, data streamed beat by beat. The block grants one port at a time by fixed priority, where a higher index wins.
- The grant is locked until the last beat of the burst is accepted.
- Sits between the DMA write channels and the Avalon interconnect master.

Parameters:
- NR, 4, number of requester ports (at least 2)
- DW, 32, data width; must be a multiple of 8
- AW, 32, address width
- BL, 4, burst-length field width
- BI, 1, burst-length base: a burst has (len - BI + 1) beats, computed modulo 2^BL

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- s_wrdy  out  NR  per-port beat accept (Avalon ~waitrequest)
- s_wval  in  NR  per-port write beat valid
- s_wlen  in  NR*BL  per-port burst length, held for the whole burst
- s_waddr  in  NR*AW  per-port burst start address, held for the whole burst
- s_wdata  in  NR*DW  per-port write data
- s_wbe  in  NR*DW/8  per-port byte enables
- s_wdone  out  NR  one-cycle pulse on the granted port when its last beat is accepted
- m_wrdy  in  1  slave ready (~waitrequest)
- m_wval  out  1  master write
- m_wlen  out  BL  master burstcount
- m_waddr  out  AW  master address
- m_wdata  out  DW  master writedata
- m_wbe  out  DW/8  master byteenable

Behaviour:
- State: en (IDLE=0 / BUSY=1), rid ($clog2(NR) bits), wcnt (BL bits), lenq (BL bits), first (1 bit).
- Reset values: en=0, rid=0, wcnt=BI, first=1, lenq=0, s_wdone=0.
- Outputs during reset: s_wrdy=0 and m_wval=0. m_wlen/m_waddr/m_wdata/m_wbe show port 0.
- IDLE state:
  - s_wrdy=0 and m_wval=0.
  - If |s_wval, rid <= highest index i with s_wval[i]=1, and en <= 1 next cycle.
  - This gives exactly one arbitration cycle per burst.
- BUSY state, mux outputs:
  - m_wval = s_wval[rid]
  - m_waddr = s_waddr[rid]
  - m_wlen = s_wlen[rid]
  - m_wdata = s_wdata[rid]
  - m_wbe = s_wbe[rid]
- BUSY state, ready: s_wrdy = m_wrdy ? (1<<rid) : 0. This path is combinational; m_wrdy is allowed to be high without m_wval.
- Beat accepted when acc = m_wval & m_wrdy.
- On an accepted first beat (first=1): lenq <= s_wlen[rid], first <= 0.
- Effective length: elen = first ? s_wlen[rid] : lenq.
- Last beat: last = acc & (wcnt == elen).
- Beat counter:
  - On acc: wcnt <= last ? BI : wcnt+1.
  - Arithmetic is BL bits, modulo 2^BL. With BI=1, len=0 means 2^BL beats.
- On last:
  - en <= 0, first <= 1.
  - s_wdone[rid] <= 1 for one cycle, registered, so it is visible the cycle after acceptance.
  - Other ports are not granted in that same cycle. The next grant follows the idle cycle.
- Requester drops s_wval mid-burst: the grant stays locked, m_wval=0, the counter holds, and other ports stall.
- Lower-priority port valid during a locked burst: ignored until the burst ends.
- Higher-priority port valid during a locked burst: no preemption.
- Changes to s_wlen/s_waddr mid-burst are a requester protocol error. The counter still uses lenq.
- Reset asserted mid-burst: all state returns to reset values immediately. The partial burst is abandoned; downstream recovery is the system's job.
- Latency: the first beat can be accepted 1 cycle after s_wval rises while idle.
- Throughput: len-BI+1 beats per burst, plus 1 idle cycle per burst.

Test Plan:
- Single burst, NR=4, BI=1:
  - Stimulus: port 2 len=4, addr=0x100, data 0xA0..0xA3, m_wrdy=1 throughout.
  - Required: first m_wval 1 cycle after request, 4 consecutive beats with m_waddr=0x100 and m_wlen=4, then s_wdone[2] pulse, then en=0.
- Priority:
  - Stimulus: ports 0, 1 and 3 request together, each len=2.
  - Required: grant order 3, 1, 0. One idle cycle between bursts, no interleaving of beats.
- Backpressure:
  - Stimulus: port 1 len=3; m_wrdy toggles 1,0,0,1,0,1.
  - Required: s_wrdy[1] mirrors m_wrdy; exactly 3 beats accepted; data order preserved.
- Requester gap:
  - Stimulus: port 0 len=4 drops s_wval after beat 2 for 3 cycles while port 3 requests.
  - Required: lock held on port 0, m_wval=0 during the gap, port 3 granted only after port 0's 4th beat.
- Wrap length:
  - Stimulus: BL=4, BI=1, len=0.
  - Required: 16 beats accepted before s_wdone.
- Reset mid-burst:
  - Stimulus: rst_n pulsed low after beat 1 of a len=4 burst.
  - Required: s_wrdy=0, m_wval=0, s_wdone=0 immediately; after release, a new request restarts with wcnt=BI.
